// File: rtl/sample_iter.sv
// Raster sample iterator: walks a triangle's bounding box at a chosen sample density.
// Optional SAMPLE_ITER_STATS_EN adds count_o, a saturating emitted-sample counter.
module sample_iter #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int PIPES_ITER = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_i,
  input  logic [COLORS*SIGFIG-1:0]        color_i,
  input  logic [4*SIGFIG-1:0]             box_i,
  input  logic                            valid_i,
  output logic                            halt_o,
  input  logic [3:0]                      sub_sample_i,
  input  logic                            stall_i,
  output logic [VERTS*AXIS*SIGFIG-1:0]    tri_o,
  output logic [COLORS*SIGFIG-1:0]        color_o,
  output logic [2*SIGFIG-1:0]             sample_o,
  output logic                            valid_o
`ifdef SAMPLE_ITER_STATS_EN
  ,
  output logic [31:0]                     count_o
`endif
);

  localparam int TW = VERTS*AXIS*SIGFIG;
  localparam int CW = COLORS*SIGFIG;
  localparam int BW = 1 + TW + CW + 2*SIGFIG;

  localparam logic [0:0] WAIT = 1'b0;
  localparam logic [0:0] TEST = 1'b1;

  logic [0:0]               state;
  logic [TW-1:0]            tri_r;
  logic [CW-1:0]            color_r;
  logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
  logic signed [SIGFIG-1:0] x, y;
  logic signed [SIGFIG-1:0] step, step_in;
  logic                     empty;
  logic                     cur_valid;
  logic [BW-1:0]            cur, out;

  assign empty     = (ll_x > ur_x) || (ll_y > ur_y);
  assign cur_valid = (state == TEST) && !empty;
  assign halt_o    = (state == WAIT);

  always_comb begin
    step_in = SIGFIG'(1) << RADIX;
    unique case (1'b1)
      sub_sample_i[3]: step_in = SIGFIG'(1) << RADIX;
      sub_sample_i[2]: step_in = SIGFIG'(1) << (RADIX - 1);
      sub_sample_i[1]: step_in = SIGFIG'(1) << (RADIX - 2);
      sub_sample_i[0]: step_in = SIGFIG'(1) << (RADIX - 3);
      default:         step_in = SIGFIG'(1) << RADIX;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT;
      tri_r   <= '0;
      color_r <= '0;
      ll_x    <= '0;
      ll_y    <= '0;
      ur_x    <= '0;
      ur_y    <= '0;
      x       <= '0;
      y       <= '0;
      step    <= '0;
    end else if (!stall_i) begin
      unique case (state)
        WAIT: begin
          if (valid_i) begin
            tri_r   <= tri_i;
            color_r <= color_i;
            ll_x    <= box_i[SIGFIG-1:0];
            ll_y    <= box_i[2*SIGFIG-1:SIGFIG];
            ur_x    <= box_i[3*SIGFIG-1:2*SIGFIG];
            ur_y    <= box_i[4*SIGFIG-1:3*SIGFIG];
            x       <= box_i[SIGFIG-1:0];
            y       <= box_i[2*SIGFIG-1:SIGFIG];
            step    <= step_in;
            state   <= TEST;
          end
        end
        TEST: begin
          if (empty) begin
            state <= WAIT;
          end else if (x < ur_x) begin
            x <= x + step;
          end else if (y < ur_y) begin
            x <= ll_x;
            y <= y + step;
          end else begin
            state <= WAIT;
          end
        end
      endcase
    end
  end

  assign cur = {cur_valid, tri_r, color_r, y, x};

  generate
    if (PIPES_ITER == 0) begin : g_comb
      assign out = cur;
    end else begin : g_pipe
      logic [BW-1:0] stg [PIPES_ITER];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPES_ITER; i++) stg[i] <= '0;
        end else if (!stall_i) begin
          stg[0] <= cur;
          for (int i = 1; i < PIPES_ITER; i++) stg[i] <= stg[i-1];
        end
      end
      assign out = stg[PIPES_ITER-1];
    end
  endgenerate

  assign {valid_o, tri_o, color_o, sample_o} = out;

`ifdef SAMPLE_ITER_STATS_EN
  // A held sample under stall is counted once, when it is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_o <= '0;
    end else if (!stall_i && valid_o && (count_o != '1)) begin
      count_o <= count_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sample_iter.md
SAMPLE_ITER -- requirements
Module: sample_iter

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per coordinate and color word.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits in coordinates.
REQ-003 SHALL have parameter VERTS, default 3, meaning vertices per micropolygon.
REQ-004 SHALL have parameter AXIS, default 3, meaning axes per vertex.
REQ-005 SHALL have parameter COLORS, default 3, meaning color channels.
REQ-006 SHALL have parameter PIPES_ITER, default 1, range 0..4, meaning output register stages.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port tri_i  input  VERTS*AXIS*SIGFIG  vertex coordinates, signed.
REQ-010 SHALL have port color_i  input  COLORS*SIGFIG  triangle color, unsigned.
REQ-011 SHALL have port box_i  input  4*SIGFIG  bounding box {ur_y, ur_x, ll_y, ll_x}, signed, grid-aligned.
REQ-012 SHALL have port valid_i  input  1  triangle/box valid.
REQ-013 SHALL have port halt_o  output  1  active-low upstream halt; 0 means do not present a new triangle.
REQ-014 SHALL have port sub_sample_i  input  4  one-hot sample density: 1000=1, 0100=4, 0010=16, 0001=64 samples/pixel.
REQ-015 SHALL have port stall_i  input  1  downstream stall, active-high.
REQ-016 SHALL have port tri_o, color_o  output  same widths as inputs  triangle and color of the emitted sample.
REQ-017 SHALL have port sample_o  output  2*SIGFIG  sample {y, x}.
REQ-018 SHALL have port valid_o  output  1  sample valid.

Function
REQ-019 SHALL implement FSM states WAIT and TEST.
REQ-020 In WAIT with valid_i=1 and stall_i=0, the block SHALL latch tri_i, color_i and box_i, set sample to (ll_x, ll_y), and enter TEST; valid_i=0 SHALL keep it in WAIT.
REQ-021 The step SHALL equal 1<<(RADIX-k), with k=0,1,2,3 for sub_sample_i 1000, 0100, 0010, 0001; sub_sample_i SHALL be sampled only at the WAIT->TEST transition.
REQ-022 In TEST each unstalled cycle SHALL emit the current sample with internal valid=1, then advance:
 - x<ur_x: x += step.
 - x==ur_x and y<ur_y: x=ll_x, y += step.
 - x==ur_x and y==ur_y: last sample emitted; go to WAIT.
REQ-023 Scan order SHALL be raster, x fastest; a degenerate box with ll==ur SHALL emit exactly one sample.
REQ-024 A box with ll_x>ur_x or ll_y>ur_y SHALL emit no samples, and the FSM SHALL return to WAIT on the next cycle.
REQ-025 halt_o SHALL be 1 in WAIT and 0 in TEST; it SHALL be driven combinationally from state.
REQ-026 stall_i=1 SHALL freeze FSM state, the sample counter and all output stages; no sample SHALL be lost or duplicated.
REQ-027 The output pipeline SHALL have PIPES_ITER stages, so latency from the sample being current to valid_o is PIPES_ITER cycles; PIPES_ITER=0 SHALL make the outputs combinational from the iterator registers.
REQ-028 Coordinate arithmetic SHALL be SIGFIG-bit two's complement; the bench SHALL keep boxes free of overflow, and the block SHALL NOT check for it.
REQ-029 valid_o SHALL be 0 in every cycle that emits no sample.

Reset
REQ-030 Asserting rst (0) SHALL take effect immediately and asynchronously: state=WAIT; halt_o=1; valid_o=0; sample_o, tri_o and color_o=0; all pipeline valids=0.
REQ-031 Reset mid-TEST SHALL abandon the triangle, and no further samples from it SHALL appear after release.

Configuration
REQ-032 Macro SAMPLE_ITER_STATS_EN, when defined, SHALL add output count_o (32 bits), the number of valid_o samples since reset, saturating at all-ones; it SHALL be held under stall_i and cleared by rst.
REQ-033 When SAMPLE_ITER_STATS_EN is undefined, count_o and its logic SHALL be absent, with function otherwise identical.

Verification
REQ-034 Bench SHALL cover: RADIX=10, density 1000, box ll=(0,0) ur=(1024,1024) -> 4 samples (0,0),(1024,0),(0,1024),(1024,1024), halt_o=0 for 4 cycles.
REQ-035 Bench SHALL cover: density 0100, same box -> step 512, 9 samples, last (1024,1024), then halt_o=1.
REQ-036 Bench SHALL cover: ll=ur=(2048,-1024) -> exactly one sample (2048,-1024); box ll_x=1024 ur_x=0 -> zero samples, FSM back in WAIT next cycle.
REQ-037 Bench SHALL cover: stall_i=1 for 3 cycles mid-scan of a 4-sample box -> outputs held, still exactly 4 samples in order; with SAMPLE_ITER_STATS_EN, count_o=4.
REQ-038 Bench SHALL cover: rst=0 after 2 of 4 samples -> valid_o=0 immediately; after release, a new triangle's samples start at its ll corner.
REQ-039 Bench SHALL cover: PIPES_ITER=0 and PIPES_ITER=3 -> first valid_o 0 and 3 cycles after TEST entry, with sample sequences identical.
